// File: rtl/calculator_pkg.sv
// Shared definitions for the RPN stack calculator: opcodes, error codes and
// the control FSM state encoding.
package calculator_pkg;

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_DUP   = 3'd4;
  localparam logic [2:0] OP_SWAP  = 3'd5;
  localparam logic [2:0] OP_DROP  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [2:0] ERR_OK        = 3'd0;
  localparam logic [2:0] ERR_FULL      = 3'd1;
  localparam logic [2:0] ERR_BIN_UNDER = 3'd2;
  localparam logic [2:0] ERR_UNA_UNDER = 3'd3;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/calculator_serial_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// start loads the operands; busy stays high for DATA_WIDTH cycles and done
// pulses on the last of them, while product already carries the full result.
module calculator_serial_multiplier #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   product
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic                    busy_q, busy_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
  logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*DATA_WIDTH-1:0] partial;
  logic                    last;

  // Accumulator after folding in the current multiplier bit; on the final
  // cycle this is the complete product.
  assign partial = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last    = (cnt_q == CW'(DATA_WIDTH - 1));
  assign busy    = busy_q;
  assign done    = busy_q && last;
  assign product = partial;

  // Next-state: load on start, otherwise step one bit per busy cycle.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start && !busy_q) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{DATA_WIDTH{1'b0}}, a};
      mplier_d = b;
    end else if (busy_q) begin
      acc_d    = partial;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  // Control state; reset aborts any multiply in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath registers need no reset; they are loaded on start.
  always_ff @(posedge clock) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

endmodule

// File: rtl/calculator_stack_machine.sv
// Parametrised RPN stack calculator with valid/ready command port.
// Optional build macro CALC_SATURATE_EN: overflowing ADD/MUL clamp to all
// ones and overflowing SUB clamps to zero; otherwise results wrap.
module calculator_stack_machine
  import calculator_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [2:0]                         cmd_op,
  input  logic [DATA_WIDTH-1:0]              cmd_data,
  output logic [DATA_WIDTH-1:0]              result,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               overflow,
  output logic [2:0]                         error,
  output logic                               busy
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int AW = $clog2(STACK_DEPTH);
`ifdef CALC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Clamp an overflowing result to the ceiling (all ones) or floor (zero).
  function automatic logic [DATA_WIDTH-1:0] fit(input logic [DATA_WIDTH-1:0] lo,
                                                input logic ovf,
                                                input logic ceil);
    if (SAT_EN && ovf) return ceil ? '1 : '0;
    return lo;
  endfunction

  logic [DATA_WIDTH-1:0]   stack_q [STACK_DEPTH];
  logic [DATA_WIDTH-1:0]   stack_d [STACK_DEPTH];
  logic [DW-1:0]           depth_q, depth_d;
  logic                    ovf_q, ovf_d;
  logic [2:0]              err_q, err_d;
  state_e                  state_q, state_d;

  logic                    mul_start, mul_busy, mul_done;
  logic [2*DATA_WIDTH-1:0] mul_product;
  logic [AW-1:0]           t_idx, n_idx, p_idx;
  logic [DATA_WIDTH-1:0]   t_val, n_val;
  logic [DATA_WIDTH:0]     add_sum, sub_diff;

  assign t_idx    = AW'(depth_q - DW'(1));
  assign n_idx    = AW'(depth_q - DW'(2));
  assign p_idx    = AW'(depth_q);
  assign t_val    = stack_q[t_idx];
  assign n_val    = stack_q[n_idx];
  assign add_sum  = {1'b0, n_val} + {1'b0, t_val};
  assign sub_diff = {1'b0, n_val} - {1'b0, t_val};

  assign result    = (depth_q == '0) ? '0 : t_val;
  assign depth     = depth_q;
  assign overflow  = ovf_q;
  assign error     = err_q;
  assign busy      = (state_q == S_MUL_BUSY) || mul_busy;
  assign cmd_ready = !busy;

  calculator_serial_multiplier #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul (
    .clock  (clock),
    .reset  (reset),
    .start  (mul_start),
    .a      (n_val),
    .b      (t_val),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  // Op decode, error checks, stack update and IDLE/MUL_BUSY sequencing.
  always_comb begin
    stack_d   = stack_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          ovf_d = 1'b0;
          err_d = ERR_OK;
          case (cmd_op)
            OP_PUSH: begin
              if (depth_q == DW'(STACK_DEPTH)) err_d = ERR_FULL;
              else begin
                stack_d[p_idx] = cmd_data;
                depth_d        = depth_q + DW'(1);
              end
            end
            OP_ADD: begin
              if (depth_q < DW'(2)) err_d = ERR_BIN_UNDER;
              else begin
                stack_d[n_idx] = fit(add_sum[DATA_WIDTH-1:0], add_sum[DATA_WIDTH], 1'b1);
                ovf_d          = add_sum[DATA_WIDTH];
                depth_d        = depth_q - DW'(1);
              end
            end
            OP_SUB: begin
              if (depth_q < DW'(2)) err_d = ERR_BIN_UNDER;
              else begin
                stack_d[n_idx] = fit(sub_diff[DATA_WIDTH-1:0], sub_diff[DATA_WIDTH], 1'b0);
                ovf_d          = sub_diff[DATA_WIDTH];
                depth_d        = depth_q - DW'(1);
              end
            end
            OP_MUL: begin
              if (depth_q < DW'(2)) err_d = ERR_BIN_UNDER;
              else begin
                mul_start = 1'b1;
                state_d   = S_MUL_BUSY;
              end
            end
            OP_DUP: begin
              if (depth_q == '0) err_d = ERR_UNA_UNDER;
              else if (depth_q == DW'(STACK_DEPTH)) err_d = ERR_FULL;
              else begin
                stack_d[p_idx] = t_val;
                depth_d        = depth_q + DW'(1);
              end
            end
            OP_SWAP: begin
              if (depth_q < DW'(2)) err_d = ERR_BIN_UNDER;
              else begin
                stack_d[t_idx] = n_val;
                stack_d[n_idx] = t_val;
              end
            end
            OP_DROP: begin
              if (depth_q == '0) err_d = ERR_UNA_UNDER;
              else depth_d = depth_q - DW'(1);
            end
            OP_CLEAR: begin
              depth_d = '0;
            end
          endcase
        end
      end
      S_MUL_BUSY: begin
        if (mul_done) begin
          stack_d[n_idx] = fit(mul_product[DATA_WIDTH-1:0],
                               |mul_product[2*DATA_WIDTH-1:DATA_WIDTH], 1'b1);
          ovf_d          = |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
          depth_d        = depth_q - DW'(1);
          state_d        = S_IDLE;
        end
      end
    endcase
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Stack storage holds its contents across reset.
  always_ff @(posedge clock) begin
    stack_q <= stack_d;
  end

endmodule

// File: tb/tb_calculator_stack_machine.sv
// Scoreboard bench for calculator_stack_machine (DATA_WIDTH=8, STACK_DEPTH=4).
// Honours CALC_SATURATE_EN in its reference model.
module tb_calculator_stack_machine;
  import calculator_pkg::*;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int DW   = $clog2(D + 1);
  localparam int MAXV = (1 << W) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [W-1:0]  result;
  logic [DW-1:0] depth;
  logic          overflow;
  logic [2:0]    error;
  logic          busy;

  calculator_stack_machine #(.DATA_WIDTH(W), .STACK_DEPTH(D)) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .result   (result),
    .depth    (depth),
    .overflow (overflow),
    .error    (error),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int res;
    int dep;
    int ovf;
    int err;
    bit mul;
  } exp_t;

  exp_t sb[$];
  int   stk[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: an unbounded queue used as a stack, integer arithmetic,
  // then range-limited to DATA_WIDTH bits.
  task automatic model_apply(input logic [2:0] op, input int data, output exp_t e);
    int t, n, r;
    e.ovf = 0; e.err = 0; e.mul = 0;
    case (op)
      OP_PUSH: if (stk.size() == D) e.err = 1; else stk.push_back(data);
      OP_ADD, OP_SUB, OP_MUL: begin
        if (stk.size() < 2) e.err = 2;
        else begin
          t = stk.pop_back();
          n = stk.pop_back();
          if (op == OP_ADD)      r = n + t;
          else if (op == OP_SUB) r = n - t;
          else                   r = n * t;
          if (r > MAXV || r < 0) begin
            e.ovf = 1;
`ifdef CALC_SATURATE_EN
            r = (r < 0) ? 0 : MAXV;
`else
            r = ((r % (MAXV + 1)) + (MAXV + 1)) % (MAXV + 1);
`endif
          end
          stk.push_back(r);
          e.mul = (op == OP_MUL);
        end
      end
      OP_DUP: begin
        if (stk.size() == 0) e.err = 3;
        else if (stk.size() == D) e.err = 1;
        else stk.push_back(stk[$]);
      end
      OP_SWAP: begin
        if (stk.size() < 2) e.err = 2;
        else begin
          t = stk.pop_back();
          n = stk.pop_back();
          stk.push_back(t);
          stk.push_back(n);
        end
      end
      OP_DROP: if (stk.size() == 0) e.err = 3; else void'(stk.pop_back());
      default: stk.delete();
    endcase
    e.dep = stk.size();
    e.res = (stk.size() != 0) ? stk[$] : 0;
  endtask

  // Present a command, hold it until accepted, record the expected outcome.
  task automatic send(input logic [2:0] op, input logic [W-1:0] data, output time acc_t);
    exp_t e;
    int   waited = 0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    #1;
    while (!cmd_ready && waited < 100) begin
      @(negedge clock); #1;
      waited++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", 0, 1);
      cmd_valid = 1'b0;
      acc_t = 0;
      return;
    end
    @(posedge clock);
    acc_t = $time;
    model_apply(op, int'(data), e);
    sb.push_back(e);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; cmd_valid = 1'b0;
    sb.delete(); stk.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: notices completions at the DUT interface and checks them.
  initial begin : monitor
    bit         acc, pending, done_now;
    logic [2:0] op;
    int         bcnt;
    exp_t       e;
    pending = 0; bcnt = 0;
    forever begin
      @(negedge clock); #4;
      acc = cmd_valid && cmd_ready && !reset;
      op  = cmd_op;
      @(posedge clock); #1;
      done_now = 0;
      if (reset) begin
        pending = 0;
        continue;
      end
      if (pending) begin
        if (busy) begin
          bcnt++;
          if (bcnt > 4 * W) begin
            check("mul_busy_timeout", bcnt, W);
            pending = 0;
          end
        end else begin
          done_now = 1; pending = 0;
        end
      end else if (acc) begin
        if (op == OP_MUL && busy) begin
          pending = 1; bcnt = 1;
        end else begin
          done_now = 1; bcnt = 0;
        end
      end
      if (done_now) begin
        if (sb.size() == 0) check("sb_underrun", 0, 1);
        else begin
          e = sb.pop_front();
          check("result",   int'(result),   e.res);
          check("depth",    int'(depth),    e.dep);
          check("overflow", int'(overflow), e.ovf);
          check("error",    int'(error),    e.err);
          check("ready_vs_busy", int'(cmd_ready), int'(!busy));
          if (e.mul) check("mul_busy_cycles", bcnt, W);
        end
      end
    end
  end

  initial begin : stimulus
    time t0, t1, tx;
    int  r;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_PUSH; cmd_data = '0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_result",   int'(result),    0);
    check("rst_depth",    int'(depth),     0);
    check("rst_overflow", int'(overflow),  0);
    check("rst_error",    int'(error),     0);
    check("rst_busy",     int'(busy),      0);
    check("rst_ready",    int'(cmd_ready), 1);
    @(negedge clock) reset = 1'b0;

    // ADD, then SUB with borrow
    send(OP_PUSH, 8'd3, tx); send(OP_PUSH, 8'd5, tx); send(OP_ADD, 8'd0, tx);
    send(OP_PUSH, 8'd9, tx); send(OP_SUB, 8'd0, tx);
    send(OP_CLEAR, 8'd0, tx);

    // ADD with carry out
    send(OP_PUSH, 8'd200, tx); send(OP_PUSH, 8'd100, tx); send(OP_ADD, 8'd0, tx);
    send(OP_CLEAR, 8'd0, tx);

    // multi-cycle MUL with a command held while busy
    send(OP_PUSH, 8'd20, tx); send(OP_PUSH, 8'd13, tx);
    send(OP_MUL, 8'd0, t0);
    send(OP_PUSH, 8'd2, t1);
    check("held_accept_cycles", int'((t1 - t0) / 10), W + 1);
    send(OP_CLEAR, 8'd0, tx);

    // full stack
    for (int i = 1; i <= 4; i++) send(OP_PUSH, 8'(i), tx);
    send(OP_PUSH, 8'd7, tx); send(OP_DUP, 8'd0, tx);
    send(OP_DROP, 8'd0, tx); send(OP_PUSH, 8'd8, tx);
    send(OP_CLEAR, 8'd0, tx);

    // underflows from reset
    do_reset();
    send(OP_ADD, 8'd0, tx); send(OP_DROP, 8'd0, tx); send(OP_DUP, 8'd0, tx);
    send(OP_PUSH, 8'd6, tx); send(OP_SWAP, 8'd0, tx); send(OP_MUL, 8'd0, tx);

    // reset in the middle of a multiply
    do_reset();
    send(OP_PUSH, 8'd20, tx); send(OP_PUSH, 8'd13, tx); send(OP_MUL, 8'd0, tx);
    repeat (3) @(negedge clock);
    reset = 1'b1; sb.delete(); stk.delete();
    #1;
    check("midmul_busy",   int'(busy),      0);
    check("midmul_depth",  int'(depth),     0);
    check("midmul_result", int'(result),    0);
    check("midmul_ready",  int'(cmd_ready), 1);
    @(negedge clock) reset = 1'b0;
    send(OP_PUSH, 8'd1, tx);

    // randomized command stream
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      cmd_data = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, MAXV));
      if (r < 35)      send(OP_PUSH,  cmd_data, tx);
      else if (r < 47) send(OP_ADD,   cmd_data, tx);
      else if (r < 57) send(OP_SUB,   cmd_data, tx);
      else if (r < 65) send(OP_MUL,   cmd_data, tx);
      else if (r < 73) send(OP_DUP,   cmd_data, tx);
      else if (r < 81) send(OP_SWAP,  cmd_data, tx);
      else if (r < 95) send(OP_DROP,  cmd_data, tx);
      else             send(OP_CLEAR, cmd_data, tx);
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clock);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
